// File: rtl/instr_fetch.sv
// Instruction fetch unit: streams 16-bit words from a 1-cycle-latency BRAM
// into a 2-entry {pc, instr} buffer with valid/ready, redirect, and stop.
//
// Ports:
//   i_clk, i_rst_n      clock, async active-low reset
//   i_start             pulse: begin fetching at 0x00 (IDLE only)
//   i_stop              pulse: flush and go idle (highest priority)
//   i_redirect          pulse: flush, resume at i_redirect_addr (FETCH only)
//   i_redirect_addr     redirect target
//   o_addr_read         BRAM read address (the fetch pointer)
//   i_instr_read        BRAM data, one cycle after its address
//   o_instr, o_pc       buffer head instruction and its address
//   o_instr_valid       buffer head valid
//   i_instr_ready       downstream accepts head this cycle
//   o_busy              high while fetching
//   o_fetch_count       saturating count of accepted instructions
module instr_fetch (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic        i_stop,
  input  logic        i_redirect,
  input  logic [7:0]  i_redirect_addr,
  output logic [7:0]  o_addr_read,
  input  logic [15:0] i_instr_read,
  output logic [15:0] o_instr,
  output logic [7:0]  o_pc,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic        o_busy,
  output logic [15:0] o_fetch_count
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [7:0]  fpc_q, fpc_d;
  logic        inf_q, inf_d;
  logic [7:0]  inf_pc_q, inf_pc_d;
  logic [1:0]  count_q, count_d;
  logic [23:0] ent0_q, ent0_d;
  logic [23:0] ent1_q, ent1_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic        in_fetch;
  logic        pop;
  logic        redir;
  logic        start;
  logic        flush;
  logic        issue;
  logic        push;
  logic [1:0]  occ;
  logic [23:0] new_ent;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: stop beats start
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy = (state_q == S_FETCH);
  end

  // Control decode
  always_comb begin
    in_fetch = (state_q == S_FETCH);
    o_instr_valid = (count_q != 2'd0);
    pop   = o_instr_valid & i_instr_ready;
    redir = in_fetch & i_redirect & ~i_stop;
    start = ~in_fetch & i_start & ~i_stop;
    flush = i_stop | redir;
    // occupancy including the in-flight slot; at most 2 by construction
    occ   = count_q + {1'b0, inf_q};
    issue = in_fetch & ~i_redirect & ~i_stop
          & ((occ < 2'd2) | pop);
    // a flush discards whatever the BRAM is returning this cycle
    push    = inf_q & ~flush;
    new_ent = {inf_pc_q, i_instr_read};
  end

  // Fetch pointer and in-flight tracking
  always_comb begin
    fpc_d    = fpc_q;
    inf_d    = issue;
    inf_pc_d = inf_pc_q;
    if (start) begin
      fpc_d = 8'h00;
    end else if (redir) begin
      fpc_d = i_redirect_addr;
    end else if (issue) begin
      fpc_d    = fpc_q + 8'd1;
      inf_pc_d = fpc_q;
    end
  end

  // Two-entry shift buffer; ent0 is always the head
  always_comb begin
    ent0_d  = ent0_q;
    ent1_d  = ent1_q;
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      case ({pop, push})
        2'b11: begin
          if (count_q == 2'd2) begin
            ent0_d = ent1_q;
            ent1_d = new_ent;
          end else begin
            ent0_d = new_ent;
          end
        end
        2'b10: begin
          ent0_d  = ent1_q;
          count_d = count_q - 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd0) ent0_d = new_ent;
          else                 ent1_d = new_ent;
          count_d = count_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Accepted-instruction counter; a pop alongside a flush still counts
  always_comb begin
    fcnt_d = fcnt_q;
    if (start) begin
      fcnt_d = 16'h0000;
    end else if (pop && fcnt_q != 16'hFFFF) begin
      fcnt_d = fcnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fpc_q    <= 8'h00;
      inf_q    <= 1'b0;
      inf_pc_q <= 8'h00;
      count_q  <= 2'd0;
      ent0_q   <= 24'h0;
      ent1_q   <= 24'h0;
      fcnt_q   <= 16'h0000;
    end else begin
      fpc_q    <= fpc_d;
      inf_q    <= inf_d;
      inf_pc_q <= inf_pc_d;
      count_q  <= count_d;
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign o_addr_read   = fpc_q;
  assign o_pc          = ent0_q[23:16];
  assign o_instr       = ent0_q[15:0];
  assign o_fetch_count = fcnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a synchronous BRAM model
// holding mem[n] = 0x1000 + n.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        redirect;
  logic [7:0]  raddr;
  logic [7:0]  addr_read;
  logic [15:0] instr_read;
  logic [15:0] instr;
  logic [7:0]  pc;
  logic        valid;
  logic        ready;
  logic        busy;
  logic [15:0] fcnt;

  int cmp_n = 0;
  int bad_n = 0;

  instr_fetch dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_start         (start),
    .i_stop          (stop),
    .i_redirect      (redirect),
    .i_redirect_addr (raddr),
    .o_addr_read     (addr_read),
    .i_instr_read    (instr_read),
    .o_instr         (instr),
    .o_pc            (pc),
    .o_instr_valid   (valid),
    .i_instr_ready   (ready),
    .o_busy          (busy),
    .o_fetch_count   (fcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM: one cycle read latency
  always @(posedge clk)
    instr_read <= 16'h1000 + {8'h00, addr_read};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    cmp_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 6 && !valid; n++) tick();
    chk(tag, {31'b0, valid}, 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, {31'b0, valid}, 32'd0);
    chk({tag, "_busy"},  {31'b0, busy},  32'd0);
    chk({tag, "_pc"},    {24'b0, pc},    32'd0);
    chk({tag, "_instr"}, {16'b0, instr}, 32'd0);
    chk({tag, "_fcnt"},  {16'b0, fcnt},  32'd0);
    chk({tag, "_addr"},  {24'b0, addr_read}, 32'd0);
  endtask

  logic [7:0] e;

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    redirect = 1'b0; raddr = 8'h00; ready = 1'b0;
    tick(); tick();
    chk_reset("rst");
    rst_n = 1'b1;
    tick();
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // streaming
    start = 1'b1; ready = 1'b1;
    tick();
    start = 1'b0;
    chk("st_busy", {31'b0, busy}, 32'd1);
    chk("st_addr0", {24'b0, addr_read}, 32'd0);
    chk("st_lat1", {31'b0, valid}, 32'd0);
    tick();
    chk("st_lat2", {31'b0, valid}, 32'd0);
    chk("st_addr1", {24'b0, addr_read}, 32'd1);
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("st_valid", {31'b0, valid}, 32'd1);
      chk("st_pc", {24'b0, pc}, i);
      chk("st_instr", {16'b0, instr}, 32'h1000 + i);
      tick();
    end
    chk("st_fcnt", {16'b0, fcnt}, 32'd6);

    // backpressure from a fresh start
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", {31'b0, busy}, 32'd0);
    chk("stop_valid", {31'b0, valid}, 32'd0);
    ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {31'b0, valid}, 32'd1);
      chk("bp_pc", {24'b0, pc}, 32'd0);
      chk("bp_instr", {16'b0, instr}, 32'h1000);
      chk("bp_addr", {24'b0, addr_read}, 32'd2);
      tick();
    end
    ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("bp_seq", {24'b0, pc}, i);
      tick();
    end
    chk("bp_fcnt", {16'b0, fcnt}, 32'd3);

    // start ignored while fetching
    chk("ign_pc3", {24'b0, pc}, 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_pc4", {24'b0, pc}, 32'd4);
    chk("ign_fcnt", {16'b0, fcnt}, 32'd4);
    tick();

    // redirect at head 0x05
    chk("rd_pc5", {24'b0, pc}, 32'd5);
    redirect = 1'b1; raddr = 8'h40;
    tick();
    redirect = 1'b0;
    chk("rd_valid", {31'b0, valid}, 32'd0);
    chk("rd_fcnt", {16'b0, fcnt}, 32'd6);
    chk("rd_addr", {24'b0, addr_read}, 32'h40);
    wait_valid("rd_wait");
    chk("rd_pc40", {24'b0, pc}, 32'h40);
    chk("rd_instr40", {16'b0, instr}, 32'h1040);
    tick();
    chk("rd_pc41", {24'b0, pc}, 32'h41);
    tick();

    // wrap
    redirect = 1'b1; raddr = 8'hFE;
    tick();
    redirect = 1'b0;
    wait_valid("wr_wait");
    for (int i = 0; i < 4; i++) begin
      e = 8'hFE + 8'(i);
      chk("wr_pc", {24'b0, pc}, {24'b0, e});
      chk("wr_instr", {16'b0, instr}, 32'h1000 + {24'b0, e});
      tick();
    end

    // stop beats redirect
    stop = 1'b1; redirect = 1'b1; raddr = 8'h80;
    tick();
    stop = 1'b0; redirect = 1'b0;
    chk("sr_busy", {31'b0, busy}, 32'd0);
    chk("sr_valid", {31'b0, valid}, 32'd0);
    tick();
    chk("sr_valid2", {31'b0, valid}, 32'd0);
    redirect = 1'b1; raddr = 8'h33;
    tick();
    redirect = 1'b0;
    chk("idle_redir", {31'b0, busy}, 32'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("stop_start", {31'b0, busy}, 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs_busy", {31'b0, busy}, 32'd1);
    chk("rs_fcnt", {16'b0, fcnt}, 32'd0);
    chk("rs_addr", {24'b0, addr_read}, 32'd0);
    wait_valid("rs_wait");
    chk("rs_pc", {24'b0, pc}, 32'd0);
    chk("rs_instr", {16'b0, instr}, 32'h1000);
    tick();
    ready = 1'b0;
    tick(); tick(); tick();
    chk("full_fcnt", {16'b0, fcnt}, 32'd1);
    chk("full_pc", {24'b0, pc}, 32'd1);
    chk("full_valid", {31'b0, valid}, 32'd1);

    // async reset mid-operation, checked before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    chk("post_busy", {31'b0, busy}, 32'd0);
    chk("post_valid", {31'b0, valid}, 32'd0);
    chk("post_addr", {24'b0, addr_read}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port: i_clk  input  1  rising-edge clock shared with the instruction BRAM.
REQ-002 SHALL have port: i_rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: i_start  input  1  single-cycle pulse; begin fetching at address 0x00.
REQ-004 SHALL have port: i_stop  input  1  single-cycle pulse; abort fetching, flush, return to idle.
REQ-005 SHALL have port: i_redirect  input  1  single-cycle pulse; flush and resume at i_redirect_addr.
REQ-006 SHALL have port: i_redirect_addr  input  8  new fetch address (branch/jump target).
REQ-007 SHALL have port: o_addr_read  output  8  read address to instruction BRAM.
REQ-008 SHALL have port: i_instr_read  input  16  BRAM read data, valid exactly one cycle after its address is presented.
REQ-009 SHALL have port: o_instr  output  16  instruction at buffer head.
REQ-010 SHALL have port: o_pc  output  8  address of o_instr.
REQ-011 SHALL have port: o_instr_valid  output  1  buffer head holds a valid instruction.
REQ-012 SHALL have port: i_instr_ready  input  1  downstream decode accepts head this cycle.
REQ-013 SHALL have port: o_busy  output  1  high in FETCH state.
REQ-014 SHALL have port: o_fetch_count  output  16  count of accepted instructions since start.

Function
REQ-015 SHALL implement states IDLE and FETCH; IDLE->FETCH on i_start; FETCH->IDLE on i_stop; i_stop wins over i_start and i_redirect in the same cycle.
REQ-016 SHALL hold fetch pointer fpc (8 bit); o_addr_read equals fpc combinationally; i_start sets fpc to 0x00.
REQ-017 SHALL hold a 2-entry FIFO of {pc, instr}, count 0..2, plus one in-flight flag inf and its 8-bit in-flight pc.
REQ-018 SHALL define pop = o_instr_valid AND i_instr_ready; o_instr_valid = (count != 0); o_instr/o_pc = FIFO head.
REQ-019 SHALL issue a request in a cycle when state = FETCH, no i_redirect/i_stop, and (count + inf < 2 OR pop).
REQ-020 SHALL, on issue, set inf = 1 with in-flight pc = fpc and increment fpc; otherwise clear inf at the clock edge.
REQ-021 SHALL push {in-flight pc, i_instr_read} into the FIFO at the edge following an issue, unless flushed.
REQ-022 SHALL wrap fpc from 0xFF to 0x00 without stopping.
REQ-023 SHALL, with ready held high and no redirect, sustain one instruction per cycle after a 2-cycle start latency (i_start edge, issue 0x00, first valid next cycle).
REQ-024 SHALL keep o_instr/o_pc stable while o_instr_valid = 1 and i_instr_ready = 0.
REQ-025 SHALL, on i_redirect in FETCH, empty the FIFO, discard the in-flight response, set fpc = i_redirect_addr, and issue from it on the next cycle; o_instr_valid low the cycle after redirect.
REQ-026 SHALL count a pop coinciding with i_redirect or i_stop as accepted, then flush.
REQ-027 SHALL ignore i_redirect in IDLE; SHALL ignore i_start in FETCH.
REQ-028 SHALL, on i_stop, flush FIFO and in-flight, never issue in IDLE; fpc retains its value.
REQ-029 SHALL increment o_fetch_count on each pop, saturating at 0xFFFF; i_start clears it to 0.
REQ-030 SHALL never overflow the FIFO: count + inf never exceeds 2.

Reset
REQ-031 SHALL on i_rst_n low, asynchronously: state IDLE, fpc 0x00, count 0, inf 0, o_instr 0x0000, o_pc 0x00, o_instr_valid 0, o_busy 0, o_fetch_count 0.
REQ-032 SHALL, on reset assertion mid-fetch, drop all buffered and in-flight instructions; no issue in the first cycle after reset release.

Verification
REQ-033 SHALL verify streaming: BRAM preloaded mem[n]=0x1000+n, i_start, ready=1 -> o_pc 0x00,0x01,0x02... on consecutive cycles, o_instr 0x1000,0x1001,...
REQ-034 SHALL verify backpressure: ready=0 for 5 cycles after first valid -> o_pc held 0x00, count stays 2, no further issue; ready=1 -> 0x00,0x01,0x02 with no gaps or duplicates.
REQ-035 SHALL verify redirect: at head pc 0x05, i_redirect to 0x40 -> valid low one cycle, next outputs pc 0x40,0x41; no pc 0x06/0x07 ever delivered.
REQ-036 SHALL verify wrap: i_redirect to 0xFE, ready=1 -> o_pc sequence 0xFE,0xFF,0x00,0x01.
REQ-037 SHALL verify stop/start priority: i_stop and i_redirect same cycle -> IDLE, o_busy 0, valid 0; later i_start -> fetch resumes at 0x00, o_fetch_count 0.
REQ-038 SHALL verify reset mid-operation: i_rst_n low with count=2 -> all outputs at REQ-031 values immediately, before the next clock edge.
